score_accumulator: RTL

Computes the ten signed class scores consumed by the max-select stage, which returns the index of the largest score. A frame of N_FEATURES unsigned pixels streams in, one pixel per accepted beat. Each pixel arrives alongside ten signed weights, one per class. The block accumulates ten dot products in parallel and presents them on out0..out9. acc_done is held high while the scores are final and stable, and it drives the max-select max_en directly.

---
 rtl/score_accumulator.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/score_accumulator.sv
// Ten-class streaming dot-product accumulator feeding the max-select stage.
// Optional build macro ACC_SATURATE_EN: saturating adds instead of wrapping adds.
module score_accumulator #(
    parameter int unsigned N_FEATURES = 784,
    parameter int unsigned PIX_W      = 8,
    parameter int unsigned WT_W       = 8,
    parameter int unsigned ACC_W      = 26
) (
    input  logic               clk,
    input  logic               acc_reset,
    input  logic               start,
    input  logic               in_valid,
    input  logic [PIX_W-1:0]   pixel,
    input  logic [WT_W-1:0]    w0,
    input  logic [WT_W-1:0]    w1,
    input  logic [WT_W-1:0]    w2,
    input  logic [WT_W-1:0]    w3,
    input  logic [WT_W-1:0]    w4,
    input  logic [WT_W-1:0]    w5,
    input  logic [WT_W-1:0]    w6,
    input  logic [WT_W-1:0]    w7,
    input  logic [WT_W-1:0]    w8,
    input  logic [WT_W-1:0]    w9,
    output logic               busy,
    output logic               acc_done,
    output logic [ACC_W-1:0]   out0,
    output logic [ACC_W-1:0]   out1,
    output logic [ACC_W-1:0]   out2,
    output logic [ACC_W-1:0]   out3,
    output logic [ACC_W-1:0]   out4,
    output logic [ACC_W-1:0]   out5,
    output logic [ACC_W-1:0]   out6,
    output logic [ACC_W-1:0]   out7,
    output logic [ACC_W-1:0]   out8,
    output logic [ACC_W-1:0]   out9
);

    localparam int unsigned N_CLASS = 10;
    localparam int unsigned PROD_W  = PIX_W + WT_W + 1;
    localparam int unsigned CNT_W   = (N_FEATURES > 1) ? $clog2(N_FEATURES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_FEATURES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic signed [ACC_W-1:0]   acc_q [N_CLASS];
    logic signed [ACC_W-1:0]   acc_d [N_CLASS];
    logic signed [PROD_W-1:0]  prod_c [N_CLASS];
    logic signed [ACC_W-1:0]   addend_c [N_CLASS];
    logic signed [ACC_W-1:0]   sum_c [N_CLASS];
    logic [WT_W-1:0]           wt [N_CLASS];
    logic signed [PIX_W:0]     pix_s;
    logic                      clear_c;
    logic                      beat_c;
    logic                      last_beat_c;

    assign wt[0] = w0;
    assign wt[1] = w1;
    assign wt[2] = w2;
    assign wt[3] = w3;
    assign wt[4] = w4;
    assign wt[5] = w5;
    assign wt[6] = w6;
    assign wt[7] = w7;
    assign wt[8] = w8;
    assign wt[9] = w9;

    assign out0 = acc_q[0];
    assign out1 = acc_q[1];
    assign out2 = acc_q[2];
    assign out3 = acc_q[3];
    assign out4 = acc_q[4];
    assign out5 = acc_q[5];
    assign out6 = acc_q[6];
    assign out7 = acc_q[7];
    assign out8 = acc_q[8];
    assign out9 = acc_q[9];

    // Start only acts outside ACCUM; a frame cannot be aborted by start.
    assign clear_c     = start && (state_q != S_ACCUM);
    assign beat_c      = in_valid && (state_q == S_ACCUM);
    assign last_beat_c = beat_c && (cnt_q == CNT_LAST);
    assign pix_s       = $signed({1'b0, pixel});

    // Per-class product and add; the pixel is zero-extended so it is never negative.
`ifdef ACC_SATURATE_EN
    localparam int unsigned GW = ACC_W + 1;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    logic signed [GW-1:0] sum_g_c [N_CLASS];

    always_comb begin
        for (int i = 0; i < N_CLASS; i++) begin
            prod_c[i]   = PROD_W'(pix_s) * PROD_W'($signed(wt[i]));
            addend_c[i] = ACC_W'(prod_c[i]);
            sum_g_c[i]  = GW'(acc_q[i]) + GW'(addend_c[i]);
            if (sum_g_c[i][ACC_W] != sum_g_c[i][ACC_W-1]) begin
                sum_c[i] = sum_g_c[i][ACC_W] ? ACC_MIN : ACC_MAX;
            end else begin
                sum_c[i] = sum_g_c[i][ACC_W-1:0];
            end
        end
    end
`else
    always_comb begin
        for (int i = 0; i < N_CLASS; i++) begin
            prod_c[i]   = PROD_W'(pix_s) * PROD_W'($signed(wt[i]));
            addend_c[i] = ACC_W'(prod_c[i]);
            sum_c[i]    = acc_q[i] + addend_c[i];
        end
    end
`endif

    // Accumulator and beat counter next-state.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < N_CLASS; i++) begin
            acc_d[i] = acc_q[i];
        end
        if (clear_c) begin
            cnt_d = '0;
            for (int i = 0; i < N_CLASS; i++) begin
                acc_d[i] = '0;
            end
        end else if (beat_c) begin
            cnt_d = last_beat_c ? '0 : cnt_q + CNT_W'(1);
            for (int i = 0; i < N_CLASS; i++) begin
                acc_d[i] = sum_c[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (acc_reset) begin
            cnt_q <= '0;
            for (int i = 0; i < N_CLASS; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int i = 0; i < N_CLASS; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (acc_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ACCUM;
            S_ACCUM: if (last_beat_c) state_d = S_DONE;
            S_DONE:  if (start) state_d = S_ACCUM;
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state register.
    always_comb begin
        busy     = 1'b0;
        acc_done = 1'b0;
        case (state_q)
            S_ACCUM: busy     = 1'b1;
            S_DONE:  acc_done = 1'b1;
            default: ;
        endcase
    end

endmodule
